// File: rtl/not_share_arbiter_pkg.sv
// Shared types and default sizes for the round-robin inverter scheduler.
package not_share_pkg;

  localparam int unsigned STATE_W  = 2;
  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_DW   = 8;
  localparam int unsigned DEF_CNTW = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/not_share_arbiter_if.sv
// Request/response bundle between requesters, consumer and the arbiter.
// slave: arbiter side; master: requester/consumer side.
interface not_share_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic                 ena;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      gnt;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [DW-1:0]        rsp_data;
  logic                 rsp_ready;
  logic                 busy;

  modport slave (
    input  ena, req, req_data, rsp_ready,
    output gnt, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output ena, req, req_data, rsp_ready,
    input  gnt, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/not_share_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]          req,
  input  logic [$clog2(NREQ)-1:0]  ptr,
  output logic [NREQ-1:0]          pick,
  output logic [$clog2(NREQ)-1:0]  idx,
  output logic                     any
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [IDW:0]   sum;
  logic [IDW-1:0] pos;

  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    pos  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      pos = sum[IDW-1:0];
      if (!any && req[pos]) begin
        any       = 1'b1;
        pick[pos] = 1'b1;
        idx       = pos;
      end
    end
  end
endmodule

// File: rtl/not_share_arbiter.sv
// Round-robin scheduler sharing one registered inverter among NREQ requesters.
// Optional feature: define ARB_STATS_EN for saturating per-requester grant counters (gnt_cnt).
module not_share_arbiter
  import not_share_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned DW   = DEF_DW
`ifdef ARB_STATS_EN
  , parameter int unsigned CNTW = DEF_CNTW
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  not_share_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
  , output logic [NREQ*CNTW-1:0] gnt_cnt
`endif
);
  localparam int unsigned IDW = $clog2(NREQ);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  winner;
  logic [DW-1:0]   operand;

  logic [NREQ-1:0] pick;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic [DW-1:0]   sel_data;
  logic            take;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (bus.req),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Select the operand of the current round-robin winner.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == IDW'(i)) sel_data = bus.req_data[i*DW +: DW];
    end
  end

  assign take = (state == IDLE) && bus.ena && pick_any;

  // Transaction FSM with registered grant and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      winner        <= '0;
      operand       <= '0;
      bus.gnt       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
    end else begin
      bus.gnt <= '0;
      case (state)
        IDLE: begin
          if (take) begin
            operand <= sel_data;
            winner  <= pick_idx;
            bus.gnt <= pick;
            state   <= EXEC;
          end
        end
        EXEC: begin
          bus.rsp_data  <= ~operand;
          bus.rsp_id    <= winner;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            ptr           <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Busy is decoded directly from the state register.
  always_comb begin
    bus.busy = (state != IDLE);
  end

`ifdef ARB_STATS_EN
  // Saturating grant counters, stepped on the edge that issues the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt <= '0;
    end else if (take) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (pick[i] && (gnt_cnt[i*CNTW +: CNTW] != '1))
          gnt_cnt[i*CNTW +: CNTW] <= gnt_cnt[i*CNTW +: CNTW] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_not_share_arbiter.sv
// Directed self-checking bench for not_share_arbiter (NREQ=4, DW=8).
module tb_not_share_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  not_share_arbiter_if #(.NREQ(4), .DW(8)) bus ();

`ifdef ARB_STATS_EN
  logic [7:0] gnt_cnt;
  not_share_arbiter #(.NREQ(4), .DW(8), .CNTW(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .gnt_cnt(gnt_cnt));
`else
  not_share_arbiter #(.NREQ(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  logic [7:0] d [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction from IDLE with rsp_ready high: grant, response, accept.
  task automatic txn(input int id);
    logic [7:0] nd;
    logic [3:0] g;
    nd = ~d[id];
    g  = 4'b0001 << id;
    step();
    chk("txn_gnt", 32'(bus.gnt), 32'(g));
    chk("txn_busy", 32'(bus.busy), 32'd1);
    chk("txn_valid_early", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("txn_valid", 32'(bus.rsp_valid), 32'd1);
    chk("txn_id", 32'(bus.rsp_id), 32'(id));
    chk("txn_data", 32'(bus.rsp_data), 32'(nd));
    chk("txn_gnt_off", 32'(bus.gnt), 32'd0);
    step();
    chk("txn_accept", 32'(bus.rsp_valid), 32'd0);
    chk("txn_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'hA5; d[3] = 8'h44;
    rst           = 1'b1;
    bus.ena       = 1'b1;
    bus.req       = 4'b1111;
    bus.req_data  = {d[3], d[2], d[1], d[0]};
    bus.rsp_ready = 1'b1;

    // Reset held two edges with all requests pending.
    step(); step();
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    txn(0);

    // Single request from requester 2.
    bus.req = 4'b0100;
    txn(2);

    // Fairness after a fresh reset: 0,1,2,3,0,1,2,3.
    bus.req = 4'b1111;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) txn(k % 4);

    // Backpressure on requester 1.
    bus.req = 4'b0010;
    bus.rsp_ready = 1'b0;
    step();
    chk("bp_gnt", 32'(bus.gnt), 32'b0010);
    step();
    chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_data", 32'(bus.rsp_data), 32'hDD);
      chk("bp_hold_id", 32'(bus.rsp_id), 32'd1);
      chk("bp_no_gnt", 32'(bus.gnt), 32'd0);
      chk("bp_busy", 32'(bus.busy), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    bus.req = 4'b0001;
    step();
    chk("bp_accept", 32'(bus.rsp_valid), 32'd0);
    chk("bp_idle", 32'(bus.busy), 32'd0);

    // ena dropped while in RESP (ptr=2, only req0 pending).
    bus.rsp_ready = 1'b0;
    step();
    chk("ena_gnt", 32'(bus.gnt), 32'b0001);
    step();
    chk("ena_valid", 32'(bus.rsp_valid), 32'd1);
    bus.ena = 1'b0;
    bus.req = 4'b1111;
    step();
    chk("ena_resp_hold", 32'(bus.rsp_valid), 32'd1);
    chk("ena_resp_data", 32'(bus.rsp_data), 32'hEE);
    bus.rsp_ready = 1'b1;
    step();
    chk("ena_resp_done", 32'(bus.rsp_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ena_no_gnt", 32'(bus.gnt), 32'd0);
      chk("ena_no_busy", 32'(bus.busy), 32'd0);
    end
    bus.ena = 1'b1;
    step();
    chk("ena_resume_gnt", 32'(bus.gnt), 32'b0010);

    // Reset during EXEC discards the transaction and clears ptr.
    rst = 1'b1;
    step();
    chk("rexec_gnt", 32'(bus.gnt), 32'd0);
    chk("rexec_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    step();
    chk("rexec_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rexec_ptr0_gnt", 32'(bus.gnt), 32'b0001);
    step();
    chk("rexec_id", 32'(bus.rsp_id), 32'd0);
    chk("rexec_data", 32'(bus.rsp_data), 32'hEE);
    step();

`ifdef ARB_STATS_EN
    // Counter saturation: five grants to requester 1 with CNTW=2.
    rst = 1'b1;
    bus.req = 4'b0010;
    step();
    rst = 1'b0;
    chk("cnt_rst", 32'(gnt_cnt), 32'd0);
    txn(1);
    chk("cnt_one", 32'(gnt_cnt), 32'h04);
    for (int k = 0; k < 4; k++) txn(1);
    chk("cnt_sat1", 32'(gnt_cnt[3:2]), 32'd3);
    chk("cnt_others", 32'({gnt_cnt[7:4], gnt_cnt[1:0]}), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
